countdown_timer: RTL

Four-digit mm:ss countdown timer, the down-counting counterpart of the stopwatch digit cascade. Accepts a preset time, decrements once per external 1 Hz `tick` pulse through a chain of BCD down-digits linked by borrow signals, and raises `alarm` on reaching 00:00. Sits beside the stopwatch, shares its tick source, and drives the same display digits.

---
 rtl/countdown_timer_pkg.sv | 17 +
 rtl/down_digit.sv | 44 ++++
 rtl/countdown_timer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the mm:ss countdown timer and its stopwatch sibling.
// Holds the control-state encoding and the BCD digit maxima. Both blocks
// drive the same display digits, so they must agree on these values.
package countdown_timer_pkg;

  localparam int DIGIT_W  = 4;  // width of one BCD digit
  localparam int MAX_TENS = 5;  // m10 / s10 digits count 0..5
  localparam int MAX_ONES = 9;  // m1 / s1 digits count 0..9

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } state_e;

endpackage

// File: rtl/down_digit.sv
// One BCD down-counting digit of the countdown cascade.
// Ports:
//   clk, reset : clock and asynchronous active-high reset (clears Q to 0)
//   en         : decrement enable (tick for s1, borrow of the lower digit otherwise)
//   ld, d      : synchronous load of d; ld has priority over en
//   Q          : registered digit value
//   bz         : borrow out, high when the digit is enabled while at 0
module down_digit #(
  parameter int Max       = 9,
  parameter int DataWidth = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 ld,
  input  logic [DataWidth-1:0] d,
  output logic [DataWidth-1:0] Q,
  output logic                 bz
);

  logic [DataWidth-1:0] q_q;
  logic [DataWidth-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (ld) begin
      q_d = d;
    end else if (en) begin
      q_d = (q_q == '0) ? DataWidth'(Max) : (q_q - DataWidth'(1));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q  = q_q;
  assign bz = (q_q == '0) & en;

endmodule

// File: rtl/countdown_timer.sv
// Four-digit mm:ss countdown timer.
// Loads a preset time, decrements once per tick while running and raises
// alarm on reaching 00:00. Alarm clears itself after AlarmTicks ticks, or
// earlier on start_stop / load.
// Ports:
//   clk, reset                : clock, asynchronous active-high reset
//   tick                      : one-cycle enable, nominally 1 Hz
//   load                      : capture the (clamped) preset digits
//   start_stop                : start / pause / resume
//   preset_m10..preset_s1     : preset time, BCD
//   m10, m1, s10, s1          : current time, registered
//   running                   : high while counting
//   alarm                     : high while the alarm is sounding
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int DataWidth  = DIGIT_W,
  parameter int MaxTens    = MAX_TENS,
  parameter int MaxOnes    = MAX_ONES,
  parameter int AlarmTicks = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 load,
  input  logic                 start_stop,
  input  logic [DataWidth-1:0] preset_m10,
  input  logic [DataWidth-1:0] preset_m1,
  input  logic [DataWidth-1:0] preset_s10,
  input  logic [DataWidth-1:0] preset_s1,
  output logic [DataWidth-1:0] m10,
  output logic [DataWidth-1:0] m1,
  output logic [DataWidth-1:0] s10,
  output logic [DataWidth-1:0] s1,
  output logic                 running,
  output logic                 alarm
);

  localparam int CntW = (AlarmTicks > 1) ? $clog2(AlarmTicks) : 1;

  function automatic logic [DataWidth-1:0] clamp_digit(
    input logic [DataWidth-1:0] v,
    input int                   mx
  );
    return (v > DataWidth'(mx)) ? DataWidth'(mx) : v;
  endfunction

  state_e            state_q, state_d;
  logic [CntW-1:0]   alarm_cnt_q, alarm_cnt_d;
  logic              running_q, running_d;
  logic              alarm_q, alarm_d;

  logic              dec;
  logic              load_digits;
  logic              underflow;
  logic              dig_ld;
  logic              is_zero;
  logic              at_one;
  logic              bz_s1, bz_s10, bz_m1, bz_m10;
  logic [DataWidth-1:0] d_m10, d_m1, d_s10, d_s1;

  // Decrement only once the state register already says RUN, so the tick
  // arriving with the starting start_stop does not count.
  assign dec         = tick & (state_q == ST_RUN);
  assign load_digits = load & (state_q != ST_RUN);

  // A borrow out of m10 would mean decrementing 00:00; pin the digits at
  // zero instead so the display can never wrap to 59:59.
  assign underflow = bz_m10;
  assign dig_ld    = load_digits | underflow;

  assign d_m10 = underflow ? '0 : clamp_digit(preset_m10, MaxTens);
  assign d_m1  = underflow ? '0 : clamp_digit(preset_m1,  MaxOnes);
  assign d_s10 = underflow ? '0 : clamp_digit(preset_s10, MaxTens);
  assign d_s1  = underflow ? '0 : clamp_digit(preset_s1,  MaxOnes);

  assign is_zero = (m10 == '0) & (m1 == '0) & (s10 == '0) & (s1 == '0);
  assign at_one  = (m10 == '0) & (m1 == '0) & (s10 == '0) & (s1 == DataWidth'(1));

  down_digit #(.Max(MaxOnes), .DataWidth(DataWidth)) u_s1 (
    .clk(clk), .reset(reset), .en(dec), .ld(dig_ld), .d(d_s1), .Q(s1), .bz(bz_s1)
  );
  down_digit #(.Max(MaxTens), .DataWidth(DataWidth)) u_s10 (
    .clk(clk), .reset(reset), .en(bz_s1), .ld(dig_ld), .d(d_s10), .Q(s10), .bz(bz_s10)
  );
  down_digit #(.Max(MaxOnes), .DataWidth(DataWidth)) u_m1 (
    .clk(clk), .reset(reset), .en(bz_s10), .ld(dig_ld), .d(d_m1), .Q(m1), .bz(bz_m1)
  );
  down_digit #(.Max(MaxTens), .DataWidth(DataWidth)) u_m10 (
    .clk(clk), .reset(reset), .en(bz_m1), .ld(dig_ld), .d(d_m10), .Q(m10), .bz(bz_m10)
  );

  always_comb begin
    state_d     = state_q;
    alarm_cnt_d = alarm_cnt_q;
    case (state_q)
      ST_IDLE: begin
        // load wins over start_stop; starting from 00:00 is ignored
        if (!load && start_stop && !is_zero) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // reaching 00:00 beats a simultaneous pause request
        if (dec && at_one) begin
          state_d     = ST_ALARM;
          alarm_cnt_d = '0;
        end else if (start_stop) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (load) begin
          state_d = ST_IDLE;
        end else if (start_stop) begin
          state_d = ST_RUN;
        end
      end
      ST_ALARM: begin
        if (load || start_stop) begin
          state_d     = ST_IDLE;
          alarm_cnt_d = '0;
        end else if (tick) begin
          if (alarm_cnt_q == CntW'(AlarmTicks - 1)) begin
            state_d     = ST_IDLE;
            alarm_cnt_d = '0;
          end else begin
            alarm_cnt_d = alarm_cnt_q + CntW'(1);
          end
        end
      end
      default: begin
        state_d     = ST_IDLE;
        alarm_cnt_d = '0;
      end
    endcase
    running_d = (state_d == ST_RUN);
    alarm_d   = (state_d == ST_ALARM);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      alarm_cnt_q <= '0;
      running_q   <= 1'b0;
      alarm_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      alarm_cnt_q <= alarm_cnt_d;
      running_q   <= running_d;
      alarm_q     <= alarm_d;
    end
  end

  assign running = running_q;
  assign alarm   = alarm_q;

endmodule
